// File: rtl/seg_display_pkg.sv
// rtl/seg_display_pkg.sv - character codes, display modes and segment constants
package seg_display_pkg;

    typedef logic [4:0] char_t;

    localparam char_t CH_E     = 5'h10;
    localparam char_t CH_F     = 5'h11;
    localparam char_t CH_r     = 5'h12;
    localparam char_t CH_L     = 5'h13;
    localparam char_t CH_U     = 5'h14;
    localparam char_t CH_DASH  = 5'h15;
    localparam char_t CH_BLANK = 5'h1F;

    typedef enum logic [1:0] {
        MODE_STATIC = 2'd0,
        MODE_BLINK  = 2'd1,
        MODE_SCROLL = 2'd2,
        MODE_BLANK  = 2'd3
    } mode_e;

    localparam logic [6:0] SEG_OFF = 7'h7F;

endpackage

// File: rtl/seg_char_decoder.sv
// rtl/seg_char_decoder.sv - combinational character code to active-low segment pattern
module seg_char_decoder
    import seg_display_pkg::*;
(
    input  char_t      code,
    output logic [6:0] seg
);

    // bit 0 = segment a ... bit 6 = segment g, active-low
    always_comb begin
        seg = SEG_OFF;
        case (code)
            5'h00:    seg = 7'b1000000;
            5'h01:    seg = 7'b1111001;
            5'h02:    seg = 7'b0100100;
            5'h03:    seg = 7'b0110000;
            5'h04:    seg = 7'b0011001;
            5'h05:    seg = 7'b0010010;
            5'h06:    seg = 7'b0000010;
            5'h07:    seg = 7'b1111000;
            5'h08:    seg = 7'b0000000;
            5'h09:    seg = 7'b0010000;
            5'h0A:    seg = 7'b0001000;
            5'h0B:    seg = 7'b0000011;
            5'h0C:    seg = 7'b1000110;
            5'h0D:    seg = 7'b0100001;
            5'h0E:    seg = 7'b0000110;
            5'h0F:    seg = 7'b0001110;
            CH_E:     seg = 7'b0000110;
            CH_F:     seg = 7'b0001110;
            CH_r:     seg = 7'b0101111;
            CH_L:     seg = 7'b1000111;
            CH_U:     seg = 7'b1000001;
            CH_DASH:  seg = 7'b0111111;
            default:  seg = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/seg_message_display.sv
// rtl/seg_message_display.sv - buffered multi-digit seven-segment message driver
module seg_message_display
    import seg_display_pkg::*;
#(
    parameter int NUM_DIGITS = 6,
    parameter int MSG_LEN    = 8,
    parameter int TICK_DIV   = 25_000_000
)(
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [4:0]                   char_i,
    input  logic                         char_valid_i,
    output logic                         char_ready_o,
    input  logic                         clear_i,
    input  logic [1:0]                   mode_i,
    output logic [NUM_DIGITS-1:0][6:0]   LED_o
);

    localparam int LW = $clog2(MSG_LEN + 1);
    localparam int OW = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;
    localparam int TW = $clog2(TICK_DIV);
    localparam int SW = $clog2(MSG_LEN + NUM_DIGITS) + 1;

    logic [LW-1:0] len_q;
    logic [OW-1:0] offset_q;
    logic [TW-1:0] tick_cnt_q;
    logic          visible_q;
    mode_e         mode_q;
    char_t         msg_buf [MSG_LEN];

    mode_e mode_in;
    logic  mode_chg;
    logic  tick;
    logic  push;
    logic  scrolling;
    logic  blank_all;
    logic [NUM_DIGITS-1:0][6:0] seg_sel;

    assign mode_in      = mode_e'(mode_i);
    assign mode_chg     = (mode_in != mode_q);
    assign tick         = (tick_cnt_q == TW'(TICK_DIV - 1));
    assign char_ready_o = (len_q < LW'(MSG_LEN));
    assign push         = char_valid_i && char_ready_o && !clear_i;
    assign scrolling    = (mode_q == MODE_SCROLL) && (len_q > LW'(NUM_DIGITS));
    assign blank_all    = (mode_q == MODE_BLANK) || ((mode_q == MODE_BLINK) && !visible_q);

    // Mode change and clear both restart the step timing so the first
    // scroll/blink step lands a full tick period later.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            len_q      <= '0;
            offset_q   <= '0;
            tick_cnt_q <= '0;
            visible_q  <= 1'b1;
            mode_q     <= MODE_STATIC;
        end else begin
            mode_q <= mode_in;
            if (clear_i) begin
                len_q <= '0;
            end else if (push) begin
                len_q <= len_q + 1'b1;
            end
            if (mode_chg || clear_i) begin
                tick_cnt_q <= '0;
                offset_q   <= '0;
                visible_q  <= 1'b1;
            end else if (tick) begin
                tick_cnt_q <= '0;
                visible_q  <= !visible_q;
                if (scrolling) begin
                    if (LW'(offset_q) == len_q - 1'b1) begin
                        offset_q <= '0;
                    end else begin
                        offset_q <= offset_q + 1'b1;
                    end
                end
            end else begin
                tick_cnt_q <= tick_cnt_q + 1'b1;
            end
        end
    end

    // Message storage is not reset; len alone decides what is visible.
    always_ff @(posedge clk_i) begin
        if (!rst_i && push) begin
            msg_buf[len_q[OW-1:0]] <= char_i;
        end
    end

    for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
        logic [SW-1:0] sum;
        logic [SW-1:0] wrap_idx;
        char_t         code;
        logic [6:0]    seg;

        // offset < len and k < len while scrolling, so one subtraction wraps
        always_comb begin
            sum      = SW'(offset_q) + SW'(k);
            wrap_idx = (sum >= SW'(len_q)) ? (sum - SW'(len_q)) : sum;
            if (scrolling) begin
                code = msg_buf[wrap_idx[OW-1:0]];
            end else if (SW'(k) < SW'(len_q)) begin
                code = msg_buf[k];
            end else begin
                code = CH_BLANK;
            end
        end

        seg_char_decoder u_dec (
            .code (code),
            .seg  (seg)
        );

        assign seg_sel[NUM_DIGITS-1-k] = seg;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            LED_o <= {NUM_DIGITS{SEG_OFF}};
        end else if (blank_all) begin
            LED_o <= {NUM_DIGITS{SEG_OFF}};
        end else begin
            LED_o <= seg_sel;
        end
    end

endmodule

// File: tb/tb_seg_message_display.sv
// tb/tb_seg_message_display.sv - directed scoreboard bench for seg_message_display
module tb_seg_message_display;

    logic            clk_i = 1'b0;
    logic            rst_i;
    logic [4:0]      char_i;
    logic            char_valid_i;
    logic            char_ready_o;
    logic            clear_i;
    logic [1:0]      mode_i;
    logic [5:0][6:0] LED_o;

    int n_vec = 0;
    int n_err = 0;

    localparam logic [41:0] ALL_OFF = {42{1'b1}};
    localparam logic [4:0]  B = 5'h1F;

    typedef struct {
        string       tag;
        logic [41:0] val;
    } exp_t;
    exp_t sb[$];

    seg_message_display #(
        .NUM_DIGITS (6),
        .MSG_LEN    (8),
        .TICK_DIV   (4)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .char_i       (char_i),
        .char_valid_i (char_valid_i),
        .char_ready_o (char_ready_o),
        .clear_i      (clear_i),
        .mode_i       (mode_i),
        .LED_o        (LED_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [6:0] seg(input logic [4:0] c);
        case (c)
            5'h00: return 7'h40;  5'h01: return 7'h79;  5'h02: return 7'h24;
            5'h03: return 7'h30;  5'h04: return 7'h19;  5'h05: return 7'h12;
            5'h06: return 7'h02;  5'h07: return 7'h78;  5'h08: return 7'h00;
            5'h09: return 7'h10;  5'h0A: return 7'h08;  5'h0B: return 7'h03;
            5'h0C: return 7'h46;  5'h0D: return 7'h21;  5'h0E: return 7'h06;
            5'h0F: return 7'h0E;  5'h10: return 7'h06;  5'h11: return 7'h0E;
            5'h12: return 7'h2F;  5'h13: return 7'h47;  5'h14: return 7'h41;
            5'h15: return 7'h3F;
            default: return 7'h7F;
        endcase
    endfunction

    function automatic logic [41:0] row(input logic [4:0] c0, c1, c2, c3, c4, c5);
        return {seg(c0), seg(c1), seg(c2), seg(c3), seg(c4), seg(c5)};
    endfunction

    function automatic logic [41:0] scroll_row(input int off, input int len);
        logic [41:0] v = '0;
        for (int k = 0; k < 6; k++) v = {v[34:0], seg(5'((off + k) % len))};
        return v;
    endfunction

    task automatic tick1();
        @(posedge clk_i);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick1();
    endtask

    task automatic push_c(input logic [4:0] c);
        char_i       = c;
        char_valid_i = 1'b1;
        tick1();
        char_valid_i = 1'b0;
    endtask

    task automatic do_clear();
        clear_i = 1'b1;
        tick1();
        clear_i = 1'b0;
    endtask

    task automatic exp_led(input string tag, input logic [41:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic chk_led();
        exp_t e;
        n_vec++;
        if (sb.size() == 0) begin
            n_err++;
            $error("FAIL scoreboard_empty: LED_o=%h required an expectation", LED_o);
        end else begin
            e = sb.pop_front();
            assert (LED_o === e.val) else begin
                n_err++;
                $error("FAIL %s: LED_o=%h expected %h", e.tag, LED_o, e.val);
            end
        end
    endtask

    task automatic chk_ready(input string tag, input logic v);
        n_vec++;
        assert (char_ready_o === v) else begin
            n_err++;
            $error("FAIL %s: char_ready_o=%b expected %b", tag, char_ready_o, v);
        end
    endtask

    initial begin
        bit found;
        rst_i = 1'b1; char_i = '0; char_valid_i = 1'b0; clear_i = 1'b0; mode_i = 2'd0;
        ticks(2);

        exp_led("reset_led", ALL_OFF);
        chk_led();
        chk_ready("reset_ready", 1'b1);
        rst_i = 1'b0;
        ticks(2);
        exp_led("empty_after_reset", ALL_OFF);
        chk_led();

        // reset/decode
        push_c(5'h10); push_c(5'h12); push_c(5'h12);
        exp_led("decode_Err0", row(5'h10, 5'h12, 5'h12, 5'h00, B, B));
        push_c(5'h00);
        ticks(2);
        chk_led();

        do_clear();
        push_c(5'h08); push_c(5'h09); push_c(5'h0A); push_c(5'h0B); push_c(5'h0C);
        exp_led("decode_hex8_D", row(5'h08, 5'h09, 5'h0A, 5'h0B, 5'h0C, 5'h0D));
        push_c(5'h0D);
        ticks(2);
        chk_led();

        // BLANK then back to STATIC
        mode_i = 2'd3;
        exp_led("blank_mode", ALL_OFF);
        ticks(2);
        chk_led();
        mode_i = 2'd0;
        exp_led("blank_exit", row(5'h08, 5'h09, 5'h0A, 5'h0B, 5'h0C, 5'h0D));
        ticks(2);
        chk_led();

        do_clear();
        push_c(5'h0E); push_c(5'h0F); push_c(5'h13); push_c(5'h14); push_c(5'h15);
        exp_led("decode_letters", row(5'h0E, 5'h0F, 5'h13, 5'h14, 5'h15, 5'h16));
        push_c(5'h16);
        ticks(2);
        chk_led();

        // full buffer: 9 chars with valid held
        do_clear();
        char_valid_i = 1'b1;
        for (int i = 0; i < 9; i++) begin
            char_i = 5'(i);
            chk_ready($sformatf("ready_before_push%0d", i), (i < 8) ? 1'b1 : 1'b0);
            tick1();
        end
        char_valid_i = 1'b0;
        chk_ready("full_ready_low", 1'b0);
        exp_led("full_static", row(5'h00, 5'h01, 5'h02, 5'h03, 5'h04, 5'h05));
        tick1();
        chk_led();

        // scroll wrap over the 8 stored chars (a stored 9th would break the wrap)
        mode_i = 2'd2;
        ticks(2);
        for (int j = 0; j < 9; j++) begin
            exp_led($sformatf("scroll_step%0d", j), scroll_row(j % 8, 8));
            chk_led();
            ticks(4);
        end

        // clear with valid high drops the push
        clear_i = 1'b1; char_valid_i = 1'b1; char_i = 5'h03;
        tick1();
        clear_i = 1'b0; char_valid_i = 1'b0;
        chk_ready("clear_ready", 1'b1);
        exp_led("clear_blank", ALL_OFF);
        tick1();
        chk_led();
        exp_led("clear_dropped_push", row(5'h09, B, B, B, B, B));
        push_c(5'h09);
        ticks(2);
        chk_led();

        // blink
        do_clear();
        push_c(5'h11);
        push_c(5'h11);
        mode_i = 2'd1;
        ticks(2);
        exp_led("blink_on0", row(5'h11, 5'h11, B, B, B, B));   chk_led(); ticks(4);
        exp_led("blink_off0", ALL_OFF);                         chk_led(); ticks(4);
        exp_led("blink_on1", row(5'h11, 5'h11, B, B, B, B));   chk_led(); ticks(4);
        exp_led("blink_off1", ALL_OFF);                         chk_led();
        tick1();
        mode_i = 2'd0;
        ticks(2);
        exp_led("blink_to_static", row(5'h11, 5'h11, B, B, B, B));
        chk_led();
        ticks(6);
        exp_led("static_hold", row(5'h11, 5'h11, B, B, B, B));
        chk_led();

        // short scroll stays static
        do_clear();
        mode_i = 2'd2;
        push_c(5'h01); push_c(5'h02); push_c(5'h03);
        ticks(2);
        for (int i = 0; i < 40; i++) begin
            exp_led($sformatf("short_scroll_c%0d", i), row(5'h01, 5'h02, 5'h03, B, B, B));
            chk_led();
            tick1();
        end

        // growing past NUM_DIGITS starts scrolling from offset 0
        push_c(5'h04); push_c(5'h05); push_c(5'h06); push_c(5'h07);
        exp_led("grow_offset0", row(5'h01, 5'h02, 5'h03, 5'h04, 5'h05, 5'h06));
        tick1();
        chk_led();
        found = 1'b0;
        for (int i = 0; i < 6 && !found; i++) begin
            if (LED_o[5] === seg(5'h02)) found = 1'b1;
            else tick1();
        end
        n_vec++;
        assert (found) else begin
            n_err++;
            $error("FAIL grow_scroll_start: LED_o[5]=%h expected %h within 6 cycles", LED_o[5], seg(5'h02));
        end
        exp_led("grow_offset1", row(5'h02, 5'h03, 5'h04, 5'h05, 5'h06, 5'h07));
        chk_led();

        // reset mid-scroll
        rst_i = 1'b1;
        tick1();
        exp_led("midscroll_reset", ALL_OFF);
        chk_led();
        chk_ready("midscroll_reset_ready", 1'b1);
        rst_i = 1'b0;
        ticks(3);
        exp_led("after_reset_blank", ALL_OFF);
        chk_led();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
